// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: owns pc/ir/instret and walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with ready handshakes.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DECODE = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM = 3'd3,
    S_WB = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t st, st_nxt;
  logic [31:0] pc_nxt;
  logic        pc_upd, set_ill;

  logic [6:0] opc;
  logic is_load, is_store, is_branch, is_jal, is_jalr, is_system, is_alu, is_legal;

  assign opc       = ir[6:0];
  assign is_load   = (opc == 7'b0000011);
  assign is_store  = (opc == 7'b0100011);
  assign is_branch = (opc == 7'b1100011);
  assign is_jal    = (opc == 7'b1101111);
  assign is_jalr   = (opc == 7'b1100111);
  assign is_system = (opc == 7'b1110011);
  assign is_alu    = (opc == 7'b0110011) || (opc == 7'b0010011) ||
                     (opc == 7'b0110111) || (opc == 7'b0010111);
  assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr | is_alu;

  always_comb begin
    st_nxt  = st;
    pc_nxt  = pc;
    pc_upd  = 1'b0;
    set_ill = 1'b0;
    case (st)
      S_FETCH:   if (imem_ready) st_nxt = S_DECODE;
      S_DECODE: begin
        if (is_system) st_nxt = S_HALT;
        else if (!is_legal) begin
          st_nxt  = S_HALT;
          set_ill = 1'b1;
        end else st_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_load || is_store) st_nxt = S_MEM;
        else if (is_branch) begin
          pc_upd = 1'b1;
          pc_nxt = branch_taken ? alu_result : pc + 32'd4;
        end else st_nxt = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_store) begin
            pc_upd = 1'b1;
            pc_nxt = pc + 32'd4;
          end else st_nxt = S_WB;
        end
      end
      S_WB: begin
        pc_upd = 1'b1;
        if (is_jal)       pc_nxt = alu_result;
        else if (is_jalr) pc_nxt = alu_result & ~32'h1;
        else              pc_nxt = pc + 32'd4;
      end
      S_HALT:  st_nxt = S_HALT;
      default: st_nxt = S_HALT;
    endcase
    // Every retirement funnels through here; a misaligned target halts the core.
    if (pc_upd) st_nxt = (pc_nxt[1:0] != 2'b00) ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= 32'h0000_0013;
      instret    <= 32'd0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == S_FETCH && imem_ready) ir <= instr;
      if (pc_upd) begin
        pc      <= pc_nxt;
        instret <= instret + 32'd1;
        if (pc_nxt[1:0] != 2'b00) misaligned <= 1'b1;
      end
      if (set_ill) illegal <= 1'b1;
    end
  end

  assign state    = st;
  assign halted   = (st == S_HALT);
  assign imem_req = !reset && (st == S_FETCH);
  assign dmem_req = !reset && (st == S_MEM);
  assign dmem_we  = dmem_req && is_store;
  assign rf_we    = !reset && (st == S_WB) && (ir[11:7] != 5'd0);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a per-cycle vector table for a mixed
// instruction stream, plus hand sequences for halt, reset and misalignment cases.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready;
  logic [31:0] instr;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] pc, ir, instret;
  logic        rf_we, halted, illegal, misaligned;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  cpu_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_result(alu_result), .branch_taken(branch_taken),
    .pc(pc), .ir(ir), .rf_we(rf_we), .state(state), .instret(instret),
    .halted(halted), .illegal(illegal), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0000_2103;
  localparam logic [31:0] SW   = 32'h0020_2223;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_00EF;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  typedef struct {
    logic        ir_rdy;
    logic [31:0] instr;
    logic        d_rdy;
    logic [31:0] alu;
    logic        bt;
    logic [3:0]  strb;   // {imem_req, dmem_req, dmem_we, rf_we}
    logic [2:0]  st;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a, logic [31:0] b, logic c, logic [31:0] d, logic e,
                              logic [3:0] f, logic [2:0] g, logic [31:0] h, logic [31:0] i);
    vec_t v;
    v.ir_rdy = a; v.instr = b; v.d_rdy = c; v.alu = d; v.bt = e;
    v.strb = f; v.st = g; v.pc = h; v.cnt = i;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b0; instr = 32'h0; dmem_ready = 1'b0;
    alu_result = 32'h0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Fetch with immediate ready and step to the EXECUTE cycle.
  task automatic fetch_to_exec(logic [31:0] w);
    imem_ready = 1'b1; instr = w;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    logic [73:0] act, exp;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_instret", instret, 32'd0);
    chk("rst_flags", {29'd0, halted, illegal, misaligned}, 32'd0);
    chk("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
    reset = 1'b0;

    // ADDI, LW (3 wait), SW, BEQ taken/not, NOP (rd=0), JAL, ADDI wrap, JALR aligned
    tbl.push_back(mk(1, ADDI, 0, 0, 0, 4'b1000, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 4, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b1000, 0, 32'h4, 1));
    tbl.push_back(mk(1, LW, 0, 0, 0, 4'b1000, 0, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 3, 32'h4, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'b0100, 3, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 3, 32'h4, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b0100, 3, 32'h4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 4, 32'h4, 1));
    tbl.push_back(mk(1, SW, 0, 0, 0, 4'b1000, 0, 32'h8, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h8, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h8, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b0110, 3, 32'h8, 2));
    tbl.push_back(mk(1, BEQ, 0, 0, 0, 4'b1000, 0, 32'hC, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'hC, 3));
    tbl.push_back(mk(0, 0, 0, 32'h40, 1, 4'b0000, 2, 32'hC, 3));
    tbl.push_back(mk(1, BEQ, 0, 0, 0, 4'b1000, 0, 32'h40, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h40, 4));
    tbl.push_back(mk(0, 0, 0, 32'h80, 0, 4'b0000, 2, 32'h40, 4));
    tbl.push_back(mk(1, NOP, 0, 0, 0, 4'b1000, 0, 32'h44, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h44, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h44, 5));
    tbl.push_back(mk(0, 0, 1, 32'h200, 1, 4'b0000, 4, 32'h44, 5));
    tbl.push_back(mk(1, JAL, 0, 0, 0, 4'b1000, 0, 32'h48, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h48, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h48, 6));
    tbl.push_back(mk(0, 0, 0, 32'hFFFF_FFFC, 0, 4'b0001, 4, 32'h48, 6));
    tbl.push_back(mk(1, ADDI, 0, 0, 0, 4'b1000, 0, 32'hFFFF_FFFC, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'hFFFF_FFFC, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'hFFFF_FFFC, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 4, 32'hFFFF_FFFC, 7));
    tbl.push_back(mk(1, JALR, 0, 0, 0, 4'b1000, 0, 32'h0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 32'h0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 2, 32'h0, 8));
    tbl.push_back(mk(0, 0, 0, 32'h101, 0, 4'b0000, 4, 32'h0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b1000, 0, 32'h100, 9));

    foreach (tbl[i]) begin
      imem_ready = tbl[i].ir_rdy; instr = tbl[i].instr; dmem_ready = tbl[i].d_rdy;
      alu_result = tbl[i].alu;    branch_taken = tbl[i].bt;
      #1;
      act = {imem_req, dmem_req, dmem_we, rf_we, state, pc, instret, halted, illegal, misaligned};
      exp = {tbl[i].strb, tbl[i].st, tbl[i].pc, tbl[i].cnt, 3'b000};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec[%0d]: got strb=%b st=%0d pc=%h cnt=%0d flags=%b expected strb=%b st=%0d pc=%h cnt=%0d flags=000",
                 i, act[73:70], act[69:67], act[66:35], act[34:3], act[2:0],
                 exp[73:70], exp[69:67], exp[66:35], exp[34:3]);
      end
      @(negedge clk);
    end

    // JALR to 0x103 -> pc 0x102, misaligned halt, still retires
    fetch_to_exec(JALR);
    @(negedge clk);
    alu_result = 32'h103;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_pc", pc, 32'h102);
    chk("mis_state", {29'd0, state}, 32'd5);
    chk("mis_flags", {29'd0, halted, illegal, misaligned}, 32'b101);
    chk("mis_instret", instret, 32'd10);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("halt_absorb", {25'd0, state, imem_req, dmem_req, dmem_we, rf_we}, {25'd0, 3'd5, 4'b0000});
    idle_inputs();

    // Illegal opcode -> HALT after DECODE, instret unchanged
    do_reset();
    fetch_to_exec(BAD);
    #1;
    chk("ill_state", {29'd0, state}, 32'd5);
    chk("ill_flags", {29'd0, halted, illegal, misaligned}, 32'b110);
    chk("ill_instret", instret, 32'd0);

    // ECALL -> HALT without illegal
    do_reset();
    fetch_to_exec(ECALL);
    #1;
    chk("ecall_flags", {29'd0, state, halted, illegal, misaligned}, {29'd0, 3'd5} << 3 | 32'b100);

    // Reset mid-MEM wait abandons the access
    do_reset();
    fetch_to_exec(LW);
    @(negedge clk);
    #1;
    chk("mem_wait_req", {30'd0, dmem_req, dmem_we}, 32'b10);
    reset = 1'b1;
    #1;
    chk("rst_forces_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0; dmem_ready = 1'b1;
    #1;
    chk("mem_rst_state", {29'd0, state}, 32'd0);
    chk("mem_rst_pc", pc, 32'h0);
    chk("mem_rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'b1000);
    @(negedge clk);
    #1;
    chk("mem_rst_ignored_ready", {29'd0, state}, 32'd0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
